// File: rtl/clk_src_supervisor.sv
// clk_src_supervisor: ext/int clock mux supervisor with qualification, fallback and fabric reset stretch.
// Define CLK_SUP_AUTO_RETURN_EN to re-qualify the external clock automatically after a loss.
module clk_src_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 40000,
  parameter int RST_STRETCH    = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             locked_async,
  input  logic             ext_active_async,
  input  logic             force_int_async,
  input  logic             rearm,
  input  logic             clear_count,
  output logic             clk_int_select,
  output logic             fabric_rst_n,
  output logic             ext_lost,
  output logic [CNT_W-1:0] switch_count,
  output logic [1:0]       state
);
  localparam int QW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int SW = $clog2(RST_STRETCH + 1);
  typedef enum logic [1:0] {INT = 2'd0, QUAL = 2'd1, EXT = 2'd2} st_t;
  st_t st;
  logic [SYNC_STAGES-1:0] lk_q, ex_q, fo_q;
  logic locked_s, ext_s, force_s, lock_rise, loss, sw, armed;
  logic [QW-1:0] qual_cnt;
  logic [SW-1:0] stretch, stretch_nxt;
  assign locked_s  = lk_q[SYNC_STAGES-1];
  assign ext_s     = ex_q[SYNC_STAGES-1];
  assign force_s   = fo_q[SYNC_STAGES-1];
  assign lock_rise = lk_q[SYNC_STAGES-2] & ~locked_s;
  assign loss      = st == EXT && !ext_s;
  assign sw        = (st == EXT && (force_s || !ext_s)) ||
                     (st == QUAL && ext_s && !force_s && qual_cnt == QW'(HOLDOFF_CYCLES - 1));
  assign stretch_nxt = (sw || lock_rise) ? SW'(RST_STRETCH) : (stretch != '0) ? stretch - SW'(1) : stretch;
  assign state = st;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lk_q           <= '0;
      ex_q           <= '0;
      fo_q           <= '0;
      st             <= INT;
      qual_cnt       <= '0;
      clk_int_select <= 1'b1;
      stretch        <= '0;
      fabric_rst_n   <= 1'b0;
      switch_count   <= '0;
      ext_lost       <= 1'b0;
    end else begin
      lk_q         <= {lk_q[SYNC_STAGES-2:0], locked_async};
      ex_q         <= {ex_q[SYNC_STAGES-2:0], ext_active_async};
      fo_q         <= {fo_q[SYNC_STAGES-2:0], force_int_async};
      stretch      <= stretch_nxt;
      // next-cycle locked_s is the stage just before the synchronizer output
      fabric_rst_n <= stretch_nxt == '0 && lk_q[SYNC_STAGES-2];
      switch_count <= clear_count ? CNT_W'(sw) :
                      (sw && ~&switch_count) ? switch_count + CNT_W'(1) : switch_count;
      ext_lost     <= loss | (ext_lost & ~clear_count);
      case (st)
        INT: if (ext_s && !force_s && armed) begin
          st       <= QUAL;
          qual_cnt <= '0;
        end
        QUAL: if (!ext_s || force_s) st <= INT;
          else if (sw) begin
            st             <= EXT;
            clk_int_select <= 1'b0;
          end else qual_cnt <= qual_cnt + QW'(1);
        EXT: if (sw) begin
          st             <= INT;
          clk_int_select <= 1'b1;
        end
        default: st <= INT;
      endcase
    end
  end
`ifdef CLK_SUP_AUTO_RETURN_EN
  logic unused_rearm;
  assign unused_rearm = rearm;
  assign armed = 1'b1;
`else
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) armed <= 1'b1;
    else armed <= loss ? 1'b0 : rearm ? 1'b1 : armed;
  end
`endif
endmodule
